b_jk_ff: RTL and testbench



---
 rtl/b_jk_ff.sv | 73 +++++++
 tb/tb_b_jk_ff.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/b_jk_ff.sv
// Bank of WIDTH independent edge-triggered JK flip-flops with complementary outputs.
// Optional macro B_JK_TOGGLE_CNT_EN adds CNT_W and a counter of bit-0 toggle edges.
module b_jk_ff #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
`ifdef B_JK_TOGGLE_CNT_EN
  ,
  parameter int unsigned          CNT_W       = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
`ifdef B_JK_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b00:   q_d[i] = q_q[i];
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        default: q_d[i] = ~q_q[i];
      endcase
    end
  end

  // Reset wins over every J/K action sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

`ifdef B_JK_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counts edges where bit 0 was asked to toggle; wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (j[0] && k[0]) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_b_jk_ff.sv
// Self-checking bench for b_jk_ff: directed scenarios plus randomized J/K/reset traffic.
// The reference model uses the JK characteristic equation q' = j&~q | ~k&q.
module tb_b_jk_ff;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] RST_VAL = '0;
`ifdef B_JK_TOGGLE_CNT_EN
  localparam int unsigned CW = 2;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] qb;
`ifdef B_JK_TOGGLE_CNT_EN
  logic [CW-1:0] toggle_cnt;
  int unsigned   exp_cnt;
`endif

  logic [W-1:0] exp_q;
  int           n_cmp;
  int           n_err;

`ifdef B_JK_TOGGLE_CNT_EN
  b_jk_ff #(.WIDTH(W), .RESET_VALUE(RST_VAL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .j(j), .k(k), .q(q), .qb(qb), .toggle_cnt(toggle_cnt)
  );
`else
  b_jk_ff #(.WIDTH(W), .RESET_VALUE(RST_VAL)) dut (
    .clk(clk), .rst(rst), .j(j), .k(k), .q(q), .qb(qb)
  );
`endif

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply inputs on the falling edge, advance the model on the rising edge,
  // then settle 1 ns so callers sample away from the active edge.
  task automatic cycle(input logic [W-1:0] jv, input logic [W-1:0] kv, input logic rv);
    @(negedge clk);
    j   = jv;
    k   = kv;
    rst = rv;
    @(posedge clk);
    if (rv) begin
      exp_q = RST_VAL;
    end else begin
      exp_q = (jv & ~exp_q) | (~kv & exp_q);
    end
`ifdef B_JK_TOGGLE_CNT_EN
    if (rv) exp_cnt = 0;
    else if (jv[0] && kv[0]) exp_cnt = (exp_cnt + 1) % (1 << CW);
`endif
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle('1, '1, 1'b1);
      n_cmp++;
      if (q !== RST_VAL) begin
        n_err++;
        $display("FAIL reset_q[%0d]: got %h want %h", i, q, RST_VAL);
      end
      n_cmp++;
      if (qb !== ~RST_VAL) begin
        n_err++;
        $display("FAIL reset_qb[%0d]: got %h want %h", i, qb, ~RST_VAL);
      end
`ifdef B_JK_TOGGLE_CNT_EN
      n_cmp++;
      if (toggle_cnt !== '0) begin
        n_err++;
        $display("FAIL reset_cnt[%0d]: got %0d want 0", i, toggle_cnt);
      end
`endif
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] jk_seq [6];
    logic       q_seq  [6];
    logic [W-1:0] want;
    jk_seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11};
    q_seq  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cycle('0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle({W{jk_seq[i][1]}}, {W{jk_seq[i][0]}}, 1'b0);
      want = {W{q_seq[i]}};
      n_cmp++;
      if (q !== want) begin
        n_err++;
        $display("FAIL truth_q[%0d]: got %h want %h", i, q, want);
      end
      n_cmp++;
      if (qb !== ~want) begin
        n_err++;
        $display("FAIL truth_qb[%0d]: got %h want %h", i, qb, ~want);
      end
    end
  endtask

  task automatic test_free_running();
    cycle('0, '0, 1'b1);
    // j flips every 3 cycles (30 ns), k every 5 cycles (50 ns), both starting at 0
    for (int c = 0; c < 30; c++) begin
      cycle({W{1'((c / 3) % 2)}}, {W{1'((c / 5) % 2)}}, 1'b0);
      n_cmp++;
      if (q !== exp_q || qb !== ~exp_q) begin
        n_err++;
        $display("FAIL free_run[%0d]: q=%h qb=%h want q=%h", c, q, qb, exp_q);
      end
    end
  endtask

  task automatic test_mid_reset();
    cycle('0, '0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle('1, '1, 1'b0);
      n_cmp++;
      if (q !== {W{1'(c % 2 == 0)}}) begin
        n_err++;
        $display("FAIL mid_toggle[%0d]: got %h want %h", c, q, {W{1'(c % 2 == 0)}});
      end
    end
    cycle('1, '1, 1'b1);
    n_cmp++;
    if (q !== RST_VAL || qb !== ~RST_VAL) begin
      n_err++;
      $display("FAIL mid_reset: q=%h qb=%h want q=%h", q, qb, RST_VAL);
    end
    cycle('1, '1, 1'b0);
    n_cmp++;
    if (q !== '1) begin
      n_err++;
      $display("FAIL mid_resume: got %h want %h", q, {W{1'b1}});
    end
  endtask

  task automatic test_glitch();
    cycle('0, '0, 1'b1);
    @(negedge clk);
    k = '0;
    j = '1;
    #2;
    j = '0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (q !== '0 || qb !== '1) begin
      n_err++;
      $display("FAIL glitch: q=%h qb=%h want q=0", q, qb);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] jv;
    logic [W-1:0] kv;
    logic         rv;
    cycle('0, '0, 1'b1);
    for (int c = 0; c < 200; c++) begin
      jv = W'($urandom);
      kv = W'($urandom);
      rv = ($urandom_range(0, 15) == 0);
      cycle(jv, kv, rv);
      n_cmp++;
      if (q !== exp_q || qb !== ~exp_q) begin
        n_err++;
        $display("FAIL random[%0d]: q=%h qb=%h want q=%h", c, q, qb, exp_q);
      end
`ifdef B_JK_TOGGLE_CNT_EN
      n_cmp++;
      if (toggle_cnt !== CW'(exp_cnt)) begin
        n_err++;
        $display("FAIL random_cnt[%0d]: got %0d want %0d", c, toggle_cnt, exp_cnt);
      end
`endif
    end
  endtask

`ifdef B_JK_TOGGLE_CNT_EN
  task automatic test_toggle_cnt();
    int want_seq [5];
    want_seq = '{1, 2, 3, 0, 1};
    cycle('1, '1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle('1, '1, 1'b0);
      n_cmp++;
      if (toggle_cnt !== CW'(want_seq[c])) begin
        n_err++;
        $display("FAIL toggle_cnt[%0d]: got %0d want %0d", c, toggle_cnt, want_seq[c]);
      end
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    j     = '0;
    k     = '0;
`ifdef B_JK_TOGGLE_CNT_EN
    exp_cnt = 0;
`endif
    test_reset();
    test_truth_table();
    test_free_running();
    test_mid_reset();
    test_glitch();
    test_random();
`ifdef B_JK_TOGGLE_CNT_EN
    test_toggle_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
